alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU (add/sub/and/or/slt, 4-bit control code) between two requesters, e.g. the main execute stage (port 0) and the branch/address helper (port 1).
- Accepts operations via valid/ready, grants round-robin, drives the ALU from registered operands and captures the result.
- Returns each result on a per-requester response channel with valid/ready handshake.
- One operation in flight at a time.

---
 rtl/alu_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for the shared combinational ALU: round-robin grant,
// one operation in flight, registered ALU drive and per-requester response channel.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][3:0]        req_op,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    input  logic [1:0][TAG_W-1:0]  req_tag,
    output logic [3:0]             alu_ctr,
    output logic [DATA_W-1:0]      alu_in1,
    output logic [DATA_W-1:0]      alu_in2,
    input  logic [DATA_W-1:0]      alu_res,
    input  logic                   alu_zero,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [DATA_W-1:0]      resp_result,
    output logic                   resp_zero,
    output logic                   resp_err,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   busy
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               ptr_r;
    logic               owner_r;
    logic               grant_s;
    logic               accept_s;
    logic [3:0]         op_r;
    logic               err_r;
    logic [TAG_W-1:0]   tag_r;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    // Grant selection: pointer requester wins if valid, otherwise the other one
    always_comb begin
        grant_s = ptr_r;
        if (req_valid[ptr_r]) begin
            grant_s = ptr_r;
        end else begin
            grant_s = ~ptr_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = RESP;
            RESP: begin
                if (resp_ready[owner_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Request-side outputs decoded from state and grant
    always_comb begin
        req_ready = 2'b00;
        if (state_r == IDLE && req_valid[grant_s]) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
        accept_s = |(req_valid & req_ready);
        busy     = (state_r != IDLE);
    end

    // Operation latch, ALU drive and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r       <= 1'b0;
            owner_r     <= 1'b0;
            op_r        <= 4'b0000;
            err_r       <= 1'b0;
            tag_r       <= {TAG_W{1'b0}};
            alu_ctr     <= 4'b0000;
            alu_in1     <= {DATA_W{1'b0}};
            alu_in2     <= {DATA_W{1'b0}};
            resp_valid  <= 2'b00;
            resp_result <= {DATA_W{1'b0}};
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            resp_tag    <= {TAG_W{1'b0}};
        end else begin
            if (accept_s) begin
                owner_r <= grant_s;
                ptr_r   <= ~grant_s;
                op_r    <= req_op[grant_s];
                tag_r   <= req_tag[grant_s];
                err_r   <= ~op_legal(req_op[grant_s]);
                // ALU inputs only move on accept, so they hold outside EXEC
                if (op_legal(req_op[grant_s])) begin
                    alu_ctr <= req_op[grant_s];
                    alu_in1 <= req_a[grant_s];
                    alu_in2 <= req_b[grant_s];
                end else begin
                    alu_ctr <= OP_ADD;
                    alu_in1 <= {DATA_W{1'b0}};
                    alu_in2 <= {DATA_W{1'b0}};
                end
            end
            if (state_r == EXEC) begin
                resp_valid <= owner_r ? 2'b10 : 2'b01;
                resp_err   <= err_r;
                resp_tag   <= tag_r;
                if (err_r) begin
                    resp_result <= {DATA_W{1'b0}};
                    resp_zero   <= 1'b1;
                end else begin
                    resp_result <= alu_res;
                    resp_zero   <= (op_r == OP_SUB) ? alu_zero : (alu_res == {DATA_W{1'b0}});
                end
            end
            if (state_r == RESP && resp_ready[owner_r]) begin
                resp_valid <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter; expectations come from a
// transaction-level timeline model and a plain-arithmetic ALU reference.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int TW = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0][3:0]    req_op;
    logic [1:0][DW-1:0] req_a;
    logic [1:0][DW-1:0] req_b;
    logic [1:0][TW-1:0] req_tag;
    logic [3:0]         alu_ctr;
    logic [DW-1:0]      alu_in1;
    logic [DW-1:0]      alu_in2;
    logic [DW-1:0]      alu_res;
    logic               alu_zero;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [DW-1:0]      resp_result;
    logic               resp_zero;
    logic               resp_err;
    logic [TW-1:0]      resp_tag;
    logic               busy;

    alu_share_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_ctr(alu_ctr), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // The shared ALU the arbiter drives
    always_comb begin
        case (alu_ctr)
            4'b0010: alu_res = alu_in1 + alu_in2;
            4'b0110: alu_res = alu_in1 - alu_in2;
            4'b0000: alu_res = alu_in1 & alu_in2;
            4'b0001: alu_res = alu_in1 | alu_in2;
            4'b0111: alu_res = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
            default: alu_res = 32'd0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: result, zero, err of one operation
    task automatic ref_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] res, output logic z, output logic err);
        err = 1'b0;
        res = 32'd0;
        if (op == 4'd2) res = a + b;
        else if (op == 4'd6) res = a - b;
        else if (op == 4'd0) res = a & b;
        else if (op == 4'd1) res = a | b;
        else if (op == 4'd7) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else err = 1'b1;
        z = err ? 1'b1 : (res == 32'd0);
    endtask

    // Model state
    int          cyc = 0;
    bit          out_m = 0;
    int          acc_c = 0;
    int          own_m = 0;
    int          pref_m = 0;
    int          acc_port;
    logic [DW-1:0] e_res, e_in1, e_in2;
    logic          e_zero, e_err;
    logic [3:0]    e_ctr;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] last_res;
    logic          last_zero, last_err;
    logic [TW-1:0] last_tag;
    int            last_owner;

    // One clock cycle: sample mid-cycle against the model, then advance past the edge
    task automatic step();
        int g;
        acc_port = -1;
        #3;
        if (reset) begin
            out_m  = 0;
            pref_m = 0;
        end else if (!out_m) begin
            g = -1;
            if (req_valid[pref_m]) g = pref_m;
            else if (req_valid[1-pref_m]) g = 1 - pref_m;
            check_eq("idle_req_ready", req_ready, (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10));
            check_eq("idle_busy", busy, 1'b0);
            check_eq("idle_resp_valid", resp_valid, 2'b00);
            if (g >= 0) begin
                ref_op(req_op[g], req_a[g], req_b[g], e_res, e_zero, e_err);
                e_tag = req_tag[g];
                e_ctr = e_err ? 4'b0010 : req_op[g];
                e_in1 = e_err ? 32'd0 : req_a[g];
                e_in2 = e_err ? 32'd0 : req_b[g];
                out_m = 1; acc_c = cyc; own_m = g; pref_m = 1 - g; acc_port = g;
            end
        end else if (cyc == acc_c + 1) begin
            check_eq("exec_req_ready", req_ready, 2'b00);
            check_eq("exec_busy", busy, 1'b1);
            check_eq("exec_resp_valid", resp_valid, 2'b00);
            check_eq("exec_alu_ctr", alu_ctr, e_ctr);
            check_eq("exec_alu_in1", alu_in1, e_in1);
            check_eq("exec_alu_in2", alu_in2, e_in2);
        end else begin
            check_eq("resp_req_ready", req_ready, 2'b00);
            check_eq("resp_busy", busy, 1'b1);
            check_eq("resp_valid", resp_valid, own_m == 0 ? 2'b01 : 2'b10);
            check_eq("resp_result", resp_result, e_res);
            check_eq("resp_zero", resp_zero, e_zero);
            check_eq("resp_err", resp_err, e_err);
            check_eq("resp_tag", resp_tag, e_tag);
            if (resp_ready[own_m]) begin
                out_m = 0;
                last_res = resp_result; last_zero = resp_zero; last_err = resp_err;
                last_tag = resp_tag; last_owner = own_m;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int p, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag);
        bit got;
        got = 0;
        req_valid[p] = 1'b1; req_op[p] = op; req_a[p] = a; req_b[p] = b; req_tag[p] = tag;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (acc_port == p) got = 1;
        end
        check_eq("issue_accepted", got, 1'b1);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && out_m; i++) step();
        check_eq("wait_done_timeout", out_m, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [3:0] legal_ops [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7};
    int grants[$];

    initial begin
        reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        step();
        step();
        reset = 1'b0;
        #3;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_resp_valid", resp_valid, 2'b00);
        check_eq("rst_alu_ctr", alu_ctr, 4'd0);
        check_eq("rst_resp_result", resp_result, 32'd0);
        check_eq("rst_resp_tag", resp_tag, 4'd0);
        @(posedge clk); #1; cyc++;

        // Basic add and sub cases
        resp_ready = 2'b11;
        issue(0, 4'b0010, 32'd5, 32'd7, 4'd3);
        wait_done();
        check_eq("add_result", last_res, 32'd12);
        check_eq("add_zero", last_zero, 1'b0);
        check_eq("add_tag", last_tag, 4'd3);
        check_eq("add_err", last_err, 1'b0);
        check_eq("add_owner", last_owner, 0);
        issue(1, 4'b0110, 32'd9, 32'd9, 4'd5);
        wait_done();
        check_eq("sub_eq_result", last_res, 32'd0);
        check_eq("sub_eq_zero", last_zero, 1'b1);
        check_eq("sub_eq_owner", last_owner, 1);
        issue(1, 4'b0110, 32'd3, 32'd9, 4'd6);
        wait_done();
        check_eq("sub_neg_result", last_res, 32'hFFFF_FFFA);
        check_eq("sub_neg_zero", last_zero, 1'b0);

        // Contention alternates starting with requester 0 after reset
        do_reset();
        req_op[0] = 4'd2; req_a[0] = 32'd1; req_b[0] = 32'd2; req_tag[0] = 4'd1;
        req_op[1] = 4'd1; req_a[1] = 32'hF0; req_b[1] = 32'h0F; req_tag[1] = 4'd2;
        req_valid = 2'b11;
        for (int i = 0; i < 16; i++) begin
            step();
            if (acc_port >= 0) grants.push_back(acc_port);
        end
        req_valid = 2'b00;
        wait_done();
        check_eq("alt_count", grants.size() >= 4, 1'b1);
        foreach (grants[k]) check_eq("alt_order", grants[k], k % 2);

        // Back-pressure on the response channel
        resp_ready = 2'b00;
        issue(0, 4'b0000, 32'hF0F0, 32'hFF00, 4'd7);
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) step();
        resp_ready = 2'b10;
        step();
        check_eq("nonowner_ready_ignored", out_m, 1'b1);
        resp_ready = 2'b01;
        step();
        req_valid = 2'b00;
        check_eq("hold_release_result", last_res, 32'hF000);
        step();
        resp_ready = 2'b11;

        // Illegal op code
        issue(0, 4'b1111, 32'hDEAD, 32'd1, 4'd9);
        wait_done();
        check_eq("ill_err", last_err, 1'b1);
        check_eq("ill_result", last_res, 32'd0);
        check_eq("ill_zero", last_zero, 1'b1);
        check_eq("ill_tag", last_tag, 4'd9);

        // Reset during EXEC
        issue(1, 4'd2, 32'd1, 32'd1, 4'd4);
        do_reset();
        #3;
        check_eq("rst_exec_busy", busy, 1'b0);
        check_eq("rst_exec_resp_valid", resp_valid, 2'b00);
        check_eq("rst_exec_alu_ctr", alu_ctr, 4'd0);
        @(posedge clk); #1; cyc++;
        req_valid = 2'b11;
        step();
        check_eq("rst_exec_ptr0", acc_port, 0);
        req_valid = 2'b00;
        wait_done();

        // Reset during RESP
        resp_ready = 2'b00;
        issue(0, 4'd7, 32'hFFFF_FFFF, 32'd1, 4'd8);
        step();
        step();
        do_reset();
        #3;
        check_eq("rst_resp_busy", busy, 1'b0);
        check_eq("rst_resp_resp_valid", resp_valid, 2'b00);
        @(posedge clk); #1; cyc++;
        resp_ready = 2'b11;
        for (int i = 0; i < 3; i++) step();
        issue(1, 4'd7, 32'hFFFF_FFFF, 32'd1, 4'd2);
        wait_done();
        check_eq("post_rst_slt", last_res, 32'd1);
        check_eq("post_rst_owner", last_owner, 1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            resp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc_port == i) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_op[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
                        req_a[i] = $urandom;
                        req_b[i] = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
                        req_tag[i] = 4'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
